// File: rtl/battleship_pkg.sv
// battleship_pkg: board geometry and picker FSM state type
// shared by the PC shot picker and its LFSR.
package battleship_pkg;

  localparam int NUM_CASILLAS = 25;
  localparam int CASILLA_W    = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PICK = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Ports: clk, rst (async, active low), q = state (SEED on reset).
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= SEED;
    else      q <= {q[6:0], fb};
  end

endmodule

// File: rtl/pc_shot_picker.sv
// pc_shot_picker: picks a not-yet-fired 5x5 cell for the PC per enable edge.
// Ports: clk, rst(n), enable, clear -> casilla, valid, busy, shots, full.
module pc_shot_picker
  import battleship_pkg::*;
#(
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         MAX_TRIES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  output logic [CASILLA_W-1:0] casilla,
  output logic                 valid,
  output logic                 busy,
  output logic [CASILLA_W-1:0] shots,
  output logic                 full
);

  localparam logic [CASILLA_W-1:0] NCELL =
    CASILLA_W'(NUM_CASILLAS);
  localparam logic [7:0] TRY_LIM = 8'(MAX_TRIES);

  state_t                  state;
  logic [7:0]              lfsr;
  logic                    en_q;
  logic [NUM_CASILLAS-1:0] hist;
  logic [7:0]              tries;
  logic [CASILLA_W-1:0]    idx;

  logic                    req;
  logic [CASILLA_W-1:0]    sel;
  logic [31:0]             hist_ext;
  logic                    free;
  logic [7:0]              tries_nxt;
  logic                    unused_lfsr;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:5];

  assign req       = enable & ~en_q;
  assign sel       = (state == S_SCAN) ? idx : lfsr[4:0];
  // zero-extended so candidates 25..31 index a defined bit
  assign hist_ext  = 32'(hist);
  assign free      = (sel < NCELL) && !hist_ext[sel];
  assign tries_nxt = tries + 8'd1;

  assign valid = (state == S_DONE);
  assign busy  = (state != S_IDLE);
  assign full  = (shots == NCELL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      en_q    <= 1'b0;
      hist    <= '0;
      shots   <= '0;
      casilla <= '0;
      tries   <= '0;
      idx     <= '0;
    end else begin
      // edge detector tracks enable in every state
      en_q <= enable;
      if (clear) begin
        state <= S_IDLE;
        hist  <= '0;
        shots <= '0;
        tries <= '0;
        idx   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (req && !full) begin
              state <= S_PICK;
              tries <= '0;
            end
          end
          S_PICK: begin
            if (free) begin
              casilla <= sel;
              hist    <= hist | (NUM_CASILLAS'(1) << sel);
              shots   <= shots + 5'd1;
              state   <= S_DONE;
            end else begin
              tries <= tries_nxt;
              if (tries_nxt == TRY_LIM) begin
                state <= S_SCAN;
                idx   <= '0;
              end
            end
          end
          S_SCAN: begin
            // entry needs full=0, so a free cell lies at or below 24
            if (free) begin
              casilla <= sel;
              hist    <= hist | (NUM_CASILLAS'(1) << sel);
              shots   <= shots + 5'd1;
              state   <= S_DONE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
          S_DONE: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_shot_picker.sv
// tb_pc_shot_picker: directed checks of pc_shot_picker, two instances
// (default MAX_TRIES and MAX_TRIES=1), LFSR model used to time requests.
module tb_pc_shot_picker;
  import battleship_pkg::*;

  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_enable = 1'b0, a_clear = 1'b0;
  logic [4:0] a_cas, a_shots;
  logic       a_valid, a_busy, a_full;

  logic       b_enable = 1'b0, b_clear = 1'b0;
  logic [4:0] b_cas, b_shots;
  logic       b_valid, b_busy, b_full;

  pc_shot_picker #(.SEED(SEED), .MAX_TRIES(32)) dut_a (
    .clk(clk), .rst(rst), .enable(a_enable), .clear(a_clear),
    .casilla(a_cas), .valid(a_valid), .busy(a_busy),
    .shots(a_shots), .full(a_full)
  );

  pc_shot_picker #(.SEED(SEED), .MAX_TRIES(1)) dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .clear(b_clear),
    .casilla(b_cas), .valid(b_valid), .busy(b_busy),
    .shots(b_shots), .full(b_full)
  );

  function automatic logic [7:0] lf_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // reference LFSR, reset and clocked like the DUT's
  logic [7:0] m;
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= SEED;
    else      m <= lf_next(m);
  end

  int          a_vcnt = 0, b_vcnt = 0;
  logic [24:0] a_seen = '0;
  always @(negedge clk) begin
    if (a_valid) begin
      a_vcnt <= a_vcnt + 1;
      a_seen <= a_seen | (25'd1 << a_cas);
    end
    if (b_valid) b_vcnt <= b_vcnt + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_a(input string tag);
    int k = 0;
    while (!a_valid && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(a_valid), 1);
  endtask

  task automatic wait_b(input string tag);
    int k = 0;
    while (!b_valid && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(b_valid), 1);
  endtask

  task automatic pulse_a();
    tick();
    a_enable = 1'b1;
    tick();
    a_enable = 1'b0;
  endtask

  // raise enable so that the first PICK candidate equals tgt
  task automatic fire_b_at(input logic [4:0] tgt);
    logic [7:0] nx;
    int k = 0;
    nx = lf_next(m);
    while (nx[4:0] != tgt && k < 600) begin
      tick();
      nx = lf_next(m);
      k++;
    end
    b_enable = 1'b1;
    tick();
    b_enable = 1'b0;
    wait_b("b_fire_valid");
    check("b_fire_cas", 32'(b_cas), 32'(tgt));
  endtask

  // raise enable when the first PICK candidate will be rejected
  task automatic raise_b_reject();
    logic [7:0] nx;
    int k = 0;
    nx = lf_next(m);
    while (!(nx[4:0] < 5'd5 || nx[4:0] >= 5'd25) && k < 600) begin
      tick();
      nx = lf_next(m);
      k++;
    end
    b_enable = 1'b1;
  endtask

  initial begin
    int v0, lat, bz;
    logic [4:0] c0;
    logic [7:0] nx;

    repeat (3) tick();
    check("rst_a_cas",   32'(a_cas),   0);
    check("rst_a_valid", 32'(a_valid), 0);
    check("rst_a_busy",  32'(a_busy),  0);
    check("rst_a_shots", 32'(a_shots), 0);
    check("rst_a_full",  32'(a_full),  0);
    check("rst_lfsr",    32'(dut_a.u_lfsr.q), 32'(SEED));
    rst = 1'b1;
    repeat (5) tick();
    check("lfsr_seq", 32'(dut_a.u_lfsr.q), 32'(m));

    // MAX_TRIES=1: fill 0..3, then a rejected candidate must scan to 4
    fire_b_at(5'd0);
    fire_b_at(5'd1);
    fire_b_at(5'd2);
    fire_b_at(5'd3);
    raise_b_reject();
    tick();
    b_enable = 1'b0;
    lat = 1;
    while (!b_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("scan_latency", 32'(lat), 7);
    check("scan_cas", 32'(b_cas), 4);
    check("scan_shots", 32'(b_shots), 5);

    // fill the whole board on the default instance
    for (int i = 0; i < 25; i++) begin
      pulse_a();
      wait_a("fill_valid");
      repeat (40) tick();
    end
    check("fill_count", 32'(a_vcnt), 25);
    check("fill_cover", 32'(a_seen), 32'h01FF_FFFF);
    check("fill_shots", 32'(a_shots), 25);
    check("fill_full",  32'(a_full), 1);

    // request while full is ignored
    v0 = a_vcnt;
    c0 = a_cas;
    bz = 0;
    pulse_a();
    repeat (20) begin
      tick();
      if (a_busy) bz++;
    end
    check("full_busy",  32'(bz), 0);
    check("full_valid", 32'(a_vcnt - v0), 0);
    check("full_cas",   32'(c0), 32'(a_cas));

    tick();
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("clr_shots", 32'(a_shots), 0);
    check("clr_full",  32'(a_full), 0);

    // minimum latency: empty history, first candidate accepted
    nx = lf_next(m);
    lat = 0;
    while (nx[4:0] >= 5'd25 && lat < 600) begin
      tick();
      nx = lf_next(m);
      lat++;
    end
    a_enable = 1'b1;
    tick();
    a_enable = 1'b0;
    check("min_n1_valid", 32'(a_valid), 0);
    check("min_n1_busy",  32'(a_busy), 1);
    tick();
    check("min_n2_valid", 32'(a_valid), 1);
    check("min_n2_cas",   32'(a_cas), 32'(nx[4:0]));
    check("min_n2_shots", 32'(a_shots), 1);
    tick();
    check("min_n3_valid", 32'(a_valid), 0);

    for (int i = 0; i < 9; i++) begin
      pulse_a();
      wait_a("ten_valid");
      repeat (5) tick();
    end
    check("ten_shots", 32'(a_shots), 10);

    // clear and enable edge in the same cycle
    v0 = a_vcnt;
    tick();
    a_clear  = 1'b1;
    a_enable = 1'b1;
    tick();
    a_clear = 1'b0;
    tick();
    a_enable = 1'b0;
    repeat (20) tick();
    check("clr_en_shots", 32'(a_shots), 0);
    check("clr_en_valid", 32'(a_vcnt - v0), 0);
    pulse_a();
    wait_a("post_clr_valid");
    check("post_clr_shots", 32'(a_shots), 1);
    repeat (5) tick();

    // enable held high yields exactly one shot
    v0 = a_vcnt;
    tick();
    a_enable = 1'b1;
    repeat (100) tick();
    a_enable = 1'b0;
    repeat (10) tick();
    check("hold_count", 32'(a_vcnt - v0), 1);

    // enable dropped right after acceptance
    tick();
    a_enable = 1'b1;
    tick();
    check("drop_busy", 32'(a_busy), 1);
    a_enable = 1'b0;
    wait_a("drop_valid");
    check("drop_shots", 32'(a_shots), 3);
    repeat (5) tick();

    // reset in the middle of SCAN on the MAX_TRIES=1 instance
    raise_b_reject();
    tick();
    b_enable = 1'b0;
    tick();
    tick();
    check("mid_state", 32'(dut_b.state), 32'(S_SCAN));
    rst = 1'b0;
    #1;
    check("mr_cas",   32'(b_cas),   0);
    check("mr_valid", 32'(b_valid), 0);
    check("mr_busy",  32'(b_busy),  0);
    check("mr_shots", 32'(b_shots), 0);
    check("mr_full",  32'(b_full),  0);
    check("mr_lfsr",  32'(dut_b.u_lfsr.q), 32'(SEED));
    check("mr_a_shots", 32'(a_shots), 0);
    repeat (2) tick();
    v0 = b_vcnt;
    rst = 1'b1;
    repeat (20) tick();
    check("mr_novalid", 32'(b_vcnt - v0), 0);
    check("mr_lfsr_seq", 32'(dut_b.u_lfsr.q), 32'(m));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_shot_picker.md
PC_SHOT_PICKER -- requirements
Module: pc_shot_picker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port clk, reset port rst.
REQ-002 Parameter SEED, default 8'hA5, SHALL set the LFSR reset value and SHALL be nonzero.
REQ-003 Parameter MAX_TRIES, default 32, SHALL set the number of random candidates tried before the fallback scan; range 1..255.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous reset, active low.
REQ-006 enable  in  1  PC-turn level from the game FSM; a rising edge requests one shot.
REQ-007 clear  in  1  synchronous new-game clear of the shot history.
REQ-008 casilla  out  5  chosen cell, 0..24, row-major on the 5x5 board.
REQ-009 valid  out  1  one-cycle pulse; casilla is new and stable while valid is high.
REQ-010 busy  out  1  high from request acceptance until the valid cycle, inclusive.
REQ-011 shots  out  5  number of cells already fired at, 0..25.
REQ-012 full  out  1  high when shots == 25.

Function
REQ-013 The 8-bit LFSR SHALL use polynomial x^8+x^6+x^5+x^4+1 and SHALL advance every cycle in every state, so that user timing adds entropy.
REQ-014 States: IDLE, PICK, SCAN, DONE.
REQ-015 IDLE: a rising edge on enable with full=0 and clear=0 SHALL register the request, set the try counter to 0, and go to PICK.
REQ-016 IDLE: a rising edge on enable with full=1 SHALL be ignored; the block stays in IDLE and valid is not pulsed.
REQ-017 PICK: the candidate SHALL be lfsr[4:0].
REQ-018 PICK, accept case: if the candidate is < 25 and its history bit is 0, the block SHALL register casilla, set that history bit, increment shots, and go to DONE.
REQ-019 PICK, reject case: otherwise the try counter SHALL increment; when it reaches MAX_TRIES the block SHALL go to SCAN with index 0.
REQ-020 SCAN: at each index, if the history bit is 0 the block SHALL accept that index exactly as in REQ-018; otherwise the index SHALL increment by 1 per cycle.
REQ-021 The SCAN termination guarantee: SCAN always terminates because entry requires full=0, so the index never exceeds 24.
REQ-022 DONE: valid SHALL be high for exactly one cycle, after which the state returns to IDLE.
REQ-023 Minimum latency: with the enable edge sampled in cycle n and the first candidate accepted, valid SHALL be high in cycle n+2.
REQ-024 Worst-case latency: MAX_TRIES+25+2 cycles.
REQ-025 Deasserting enable after acceptance SHALL NOT abort the request.
REQ-026 Holding enable high SHALL NOT generate further requests; only a new rising edge does.
REQ-027 casilla SHALL hold its last value between requests.
REQ-028 clear SHALL take priority over everything else: history is zeroed, shots is 0, state is IDLE, and valid is 0 in the next cycle.
REQ-029 When clear and an enable edge occur in the same cycle, the enable edge SHALL be discarded.
REQ-030 clear SHALL NOT reset the LFSR.
REQ-031 The same cell SHALL never be emitted twice between clears.
REQ-032 shots SHALL never exceed 25.

Reset
REQ-033 When rst is low, the block SHALL asynchronously force: state IDLE, casilla 0, valid 0, busy 0, shots 0, full 0, history 0, LFSR = SEED, try counter 0, scan index 0, enable-edge register 0.
REQ-034 Reset asserted mid-PICK or mid-SCAN SHALL discard the request without a valid pulse.
REQ-035 Release of rst SHALL take effect on the next clk edge.

Structure
REQ-036 The shared package battleship_pkg SHALL hold NUM_CASILLAS=25, CASILLA_W=5, and the state enum type.
REQ-037 The LFSR SHALL be a sub-module lfsr8 with ports clk, rst, and q[7:0], and a parameter SEED.
REQ-038 The history SHALL be a 25-bit register inside pc_shot_picker.

Verification
REQ-039 Issue 25 enable pulses spaced 40 cycles apart: 25 valid pulses, 25 distinct casilla values covering exactly 0..24, shots=25, full=1.
REQ-040 With full=1, issue a 26th enable pulse: no valid, busy stays 0, and casilla holds its last value.
REQ-041 Set MAX_TRIES=1, pre-fire until cells 0..3 are used, then force a rejected candidate: SCAN emits casilla=4, 1 try + 5 scan cycles before valid.
REQ-042 Raise clear and an enable edge in the same cycle after 10 shots: shots=0, no valid; the next enable then yields a valid pulse with shots=1.
REQ-043 Hold enable high for 100 cycles: exactly 1 valid pulse.
REQ-044 Drop enable 1 cycle after acceptance: the valid pulse still occurs.
REQ-045 Assert rst low during SCAN: all outputs are 0 immediately, no valid after release, and the LFSR restarts at SEED.
